rr_mux_arbiter: RTL and testbench
=================================

// Module: rr_mux_arbiter
// PURPOSE
//  Round-robin arbiter sequencing a shared NR_REQ:1 keyed mux (MuxKey) between requesters.
//  Each requester offers data on a valid/ready port. The block grants one, steers the mux
//  select and registers the chosen beat into a single-entry output buffer.
//  Sits in front of any shared NPC resource port (e.g. one memory/bus port, many masters).
// PARAMETERS
//  NR_REQ    4  number of requesters (2..8)
//  DATA_LEN  8  beat width in bits
//  KEY_LEN   $clog2(NR_REQ)  localparam; select/key width
// PORTS
//  clk        in   1                  clock, all state on posedge
//  rst_n      in   1                  reset, asynchronous, active-low
//  in_valid   in   NR_REQ             per-requester beat valid
//  in_ready   out  NR_REQ             per-requester beat accepted (one-hot or zero)
//  in_data    in   NR_REQ*DATA_LEN    requester i occupies bits [i*DATA_LEN +: DATA_LEN]
//  out_valid  out  1                  output buffer holds a beat
//  out_ready  in   1                  consumer accepts beat
//  out_data   out  DATA_LEN           buffered beat
//  out_sel    out  KEY_LEN            index of requester that produced out_data
//  busy       out  1                  state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, ptr=0, gnt=0; out_valid=0, out_data=0, out_sel=0,
//   in_ready=0, busy=0. Any in-flight beat is discarded; no partial transfer is reported.
//  FSM: IDLE, GRANT.
//   IDLE: if |in_valid, gnt <= first i with in_valid[i], searching ptr, ptr+1, .. wrapping
//     mod NR_REQ. Go to GRANT. Otherwise stay in IDLE.
//   GRANT: in_ready[gnt] = in_valid[gnt] && (!out_valid || out_ready). All other in_ready=0.
//     On accept: out_data <= in_data[gnt] via mux; out_sel <= gnt; out_valid <= 1;
//       ptr <= (gnt==NR_REQ-1) ? 0 : gnt+1; go to IDLE.
//     If in_valid[gnt]=0 (requester withdrew): go to IDLE, ptr unchanged, no transfer.
//  Output buffer: out_valid && out_ready with no new accept -> out_valid <= 0.
//   A new accept in the same cycle as out_ready refills the buffer (no bubble).
//   While out_valid && !out_ready, out_data/out_sel are held stable.
//  Latency: in_valid rises at cycle 0 -> grant at edge 1 -> in_ready high in cycle 1
//   -> out_valid high after edge 2. Peak throughput is 1 beat per 2 cycles.
//  Fairness: a requester that keeps in_valid asserted waits at most NR_REQ-1 grants.
//  in_valid changes on non-granted ports never affect the current grant.
//  Mux key: entries 0..NR_REQ-1. An out-of-range key gives all-zero data (MuxKeyWithDefault, default 0).
// CONFIGURATION
//  RR_ARB_LOCK_EN defined: adds input in_last[NR_REQ] (1 bit per requester).
//   GRANT persists across beats until a beat with in_last[gnt]=1 is accepted.
//   Only then do ptr and state update as above. A withdrawn in_valid mid-burst keeps
//   the grant (state stays GRANT) and the port waits for the next beat.
//  Not defined: no in_last port; every accepted beat ends the grant (single-beat mode).
// STRUCTURE
//  Shared include rr_arb_defs.vh: state encodings ST_IDLE=1'b0, ST_GRANT=1'b1,
//   and the NR_REQ upper bound.
//  Sub-module rr_pick: combinational rotating-priority picker.
//   Inputs: req[NR_REQ], ptr[KEY_LEN]. Outputs: idx[KEY_LEN], any.
//  Data steering: existing MuxKeyWithDefault #(NR_REQ, KEY_LEN, DATA_LEN) instance, key=gnt.
// TESTING
//  1 Reset: rst_n=0 mid-GRANT with out_valid=1 -> out_valid, in_ready, busy = 0
//    immediately (async); ptr=0 after release.
//  2 Single: in_valid=4'b0100, in_data[2]=8'hA5, out_ready=1 -> in_ready=4'b0100 in cycle 1;
//    out_data=8'hA5, out_sel=2 after edge 2.
//  3 Round-robin: in_valid=4'b1111 held, out_ready=1 -> out_sel sequence 0,1,2,3,0
//    at cycles 2,4,6,8,10.
//  4 Backpressure: out_ready=0 with buffer full -> in_ready stays 0, out_data stable 10 cycles.
//    Then out_ready=1 -> buffered beat drains and the pending beat loads in the same cycle.
//  5 Withdraw: gnt=1, then in_valid[1] drops before accept -> IDLE, no out_valid, next grant
//    to valid port 3 (ptr unchanged at 1).
//  6 RR_ARB_LOCK_EN: req0 3-beat burst (in_last on beat 3), req1 valid throughout
//    -> out_sel = 0,0,0,1.

Source files
------------

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and helpers for rr_mux_arbiter: FSM state encoding and pointer wrap.
// Define RR_ARB_LOCK_EN to build the burst-lock variant (adds in_last).
package rr_mux_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } rr_state_e;

  localparam int RR_NR_REQ_MAX = 8;

  function automatic int rr_wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/MuxKeyWithDefault.sv
// Keyed mux: lut holds NR_KEY {key, data} pairs; an unmatched key yields default_out.
module MuxKeyWithDefault #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  output logic [DATA_LEN-1:0]                  out,
  input  logic [KEY_LEN-1:0]                   key,
  input  logic [DATA_LEN-1:0]                  default_out,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut
);

  localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

  always_comb begin
    out = default_out;
    for (int i = 0; i < NR_KEY; i++) begin
      if (lut[i*PAIR_LEN+DATA_LEN +: KEY_LEN] == key) begin
        out = lut[i*PAIR_LEN +: DATA_LEN];
      end
    end
  end

endmodule

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set req bit at or after ptr, wrapping mod NR_REQ.
module rr_pick
  import rr_mux_arbiter_pkg::*;
#(
  parameter int NR_REQ  = 4,
  parameter int KEY_LEN = $clog2(NR_REQ)
) (
  input  logic [NR_REQ-1:0]  req,
  input  logic [KEY_LEN-1:0] ptr,
  output logic [KEY_LEN-1:0] idx,
  output logic               any
);

  always_comb begin
    logic               found;
    int                 j;
    logic [KEY_LEN-1:0] jk;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    jk    = '0;
    for (int k = 0; k < RR_NR_REQ_MAX; k++) begin
      if (k < NR_REQ) begin
        j = int'(ptr) + k;
        if (j >= NR_REQ) j = j - NR_REQ;
        jk = KEY_LEN'(j);
        if (!found && req[jk]) begin
          idx   = jk;
          found = 1'b1;
        end
      end
    end
    any = |req;
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter steering a shared keyed mux into a single-entry output buffer.
// RR_ARB_LOCK_EN: grant is held across a burst until a beat with in_last is accepted.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter  int NR_REQ   = 4,
  parameter  int DATA_LEN = 8,
  localparam int KEY_LEN  = $clog2(NR_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NR_REQ-1:0]          in_valid,
  output logic [NR_REQ-1:0]          in_ready,
  input  logic [NR_REQ*DATA_LEN-1:0] in_data,
`ifdef RR_ARB_LOCK_EN
  input  logic [NR_REQ-1:0]          in_last,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_LEN-1:0]        out_data,
  output logic [KEY_LEN-1:0]         out_sel,
  output logic                       busy
);

  localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

  rr_state_e             state_q, state_d;
  logic [KEY_LEN-1:0]    ptr_q, ptr_d;
  logic [KEY_LEN-1:0]    gnt_q, gnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_LEN-1:0]   out_data_q, out_data_d;
  logic [KEY_LEN-1:0]    out_sel_q, out_sel_d;

  logic [KEY_LEN-1:0]    pick_idx;
  logic                  pick_any;
  logic [DATA_LEN-1:0]   mux_data;
  logic [NR_REQ*PAIR_LEN-1:0] lut;
  logic                  accept;
  logic                  burst_end;

  rr_pick #(
    .NR_REQ  (NR_REQ),
    .KEY_LEN (KEY_LEN)
  ) u_pick (
    .req (in_valid),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  for (genvar gi = 0; gi < NR_REQ; gi++) begin : g_lut
    assign lut[gi*PAIR_LEN +: PAIR_LEN] = {KEY_LEN'(gi), in_data[gi*DATA_LEN +: DATA_LEN]};
  end

  MuxKeyWithDefault #(
    .NR_KEY   (NR_REQ),
    .KEY_LEN  (KEY_LEN),
    .DATA_LEN (DATA_LEN)
  ) u_mux (
    .out         (mux_data),
    .key         (gnt_q),
    .default_out ({DATA_LEN{1'b0}}),
    .lut         (lut)
  );

  // A beat moves only if the buffer is empty or draining this same cycle.
  assign accept = (state_q == ST_GRANT) && in_valid[gnt_q] && (!out_valid_q || out_ready);

`ifdef RR_ARB_LOCK_EN
  assign burst_end = in_last[gnt_q];
`else
  assign burst_end = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_idx;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = mux_data;
          out_sel_d   = gnt_q;
          if (burst_end) begin
            ptr_d   = KEY_LEN'(rr_wrap_inc(int'(gnt_q), NR_REQ));
            state_d = ST_IDLE;
          end
        end
`ifndef RR_ARB_LOCK_EN
        else if (!in_valid[gnt_q]) begin
          state_d = ST_IDLE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready        = '0;
    in_ready[gnt_q] = accept;
    busy            = (state_q == ST_GRANT);
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: expected beats queued at drive time, popped on output handshake.
`timescale 1ns/1ps
module tb_rr_mux_arbiter;

  localparam int NR_REQ   = 4;
  localparam int DATA_LEN = 8;
  localparam int KEY_LEN  = 2;

  typedef struct {
    logic [KEY_LEN-1:0]  sel;
    logic [DATA_LEN-1:0] data;
  } beat_t;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic [NR_REQ-1:0]          in_valid = '0;
  logic [NR_REQ-1:0]          in_ready;
  logic [NR_REQ*DATA_LEN-1:0] in_data = '0;
`ifdef RR_ARB_LOCK_EN
  logic [NR_REQ-1:0]          in_last = '1;
`endif
  logic                       out_valid;
  logic                       out_ready = 1'b0;
  logic [DATA_LEN-1:0]        out_data;
  logic [KEY_LEN-1:0]         out_sel;
  logic                       busy;

  beat_t sb[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  rr_mux_arbiter #(.NR_REQ(NR_REQ), .DATA_LEN(DATA_LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef RR_ARB_LOCK_EN
    .in_last   (in_last),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int sel, input logic [7:0] data);
    beat_t b;
    b.sel  = KEY_LEN'(sel);
    b.data = data;
    sb.push_back(b);
  endtask

  task automatic set_data(input int idx, input logic [7:0] val);
    in_data[idx*DATA_LEN +: DATA_LEN] = val;
  endtask

  // Single-beat transfer from an idle arbiter with an empty, draining buffer.
  task automatic beat1(input int idx, input logic [7:0] val);
    set_data(idx, val);
    in_valid = NR_REQ'(1 << idx);
    push(idx, val);
    tick(1);
    check("beat1_ready", 32'(in_ready), 32'(1 << idx));
    check("beat1_busy", 32'(busy), 32'd1);
    tick(1);
    check("beat1_valid", 32'(out_valid), 32'd1);
    check("beat1_data", 32'(out_data), 32'(val));
    check("beat1_sel", 32'(out_sel), 32'(idx));
    in_valid = '0;
    tick(2);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        beat_t e;
        e = sb.pop_front();
        $display("beat out sel=%0d data=%02h (expect sel=%0d data=%02h)", out_sel, out_data, e.sel, e.data);
        check("sb_sel", 32'(out_sel), 32'(e.sel));
        check("sb_data", 32'(out_data), 32'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Round-robin with all requesters valid
    for (int i = 0; i < NR_REQ; i++) set_data(i, 8'(8'h10 + i));
    out_ready = 1'b1;
    in_valid  = '1;
    for (int k = 0; k < 5; k++) push(k % NR_REQ, 8'(8'h10 + (k % NR_REQ)));
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check("rr_ready", 32'(in_ready), 32'(1 << (k % NR_REQ)));
      tick(1);
      check("rr_valid", 32'(out_valid), 32'd1);
      check("rr_sel", 32'(out_sel), 32'(k % NR_REQ));
    end
    in_valid = '0;
    tick(2);
    check("rr_drain", 32'(out_valid), 32'd0);

    // Single requester 2
    beat1(2, 8'hA5);

`ifndef RR_ARB_LOCK_EN
    // Withdraw: bring ptr to 1, then requester 1 drops after being granted
    beat1(0, 8'h5A);
    set_data(1, 8'h71);
    set_data(3, 8'h73);
    in_valid = 4'b1010;
    tick(1);
    in_valid = 4'b1001;
    #1;
    check("wd_ready", 32'(in_ready), 32'd0);
    check("wd_busy", 32'(busy), 32'd1);
    tick(1);
    check("wd_idle", 32'(busy), 32'd0);
    check("wd_no_out", 32'(out_valid), 32'd0);
    tick(1);
    check("wd_next_ready", 32'(in_ready), 32'b1000);
    push(3, 8'h73);
    tick(1);
    check("wd_sel", 32'(out_sel), 32'd3);
    check("wd_data", 32'(out_data), 32'h73);
    in_valid = '0;
    tick(2);
`else
    // Bring ptr to 0 so the backpressure case starts from requester 0
    beat1(3, 8'h5A);
`endif

    // Backpressure: buffer full, pending grant must wait, then refill with no bubble
    out_ready = 1'b0;
    set_data(0, 8'hC0);
    set_data(1, 8'hC1);
    in_valid = 4'b0011;
    push(0, 8'hC0);
    push(1, 8'hC1);
    tick(1);
    check("bp_ready0", 32'(in_ready), 32'b0001);
    tick(1);
    check("bp_full", 32'(out_valid), 32'd1);
    check("bp_data0", 32'(out_data), 32'hC0);
    in_valid = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("bp_hold_ready", 32'(in_ready), 32'd0);
      check("bp_hold_data", 32'(out_data), 32'hC0);
      check("bp_hold_sel", 32'(out_sel), 32'd0);
    end
    check("bp_stall_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'b0010);
    tick(1);
    check("bp_refill_valid", 32'(out_valid), 32'd1);
    check("bp_refill_data", 32'(out_data), 32'hC1);
    check("bp_refill_sel", 32'(out_sel), 32'd1);
    in_valid = '0;
    tick(2);

    // Asynchronous reset while granted and buffer full (this beat is discarded)
    out_ready = 1'b0;
    set_data(2, 8'hE2);
    in_valid = 4'b0100;
    tick(3);
    check("ar_pre_busy", 32'(busy), 32'd1);
    check("ar_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'd0);
    check("ar_in_ready", 32'(in_ready), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_out_data", 32'(out_data), 32'd0);
    check("ar_out_sel", 32'(out_sel), 32'd0);
    in_valid  = '0;
    out_ready = 1'b1;
    tick(1);
    rst_n = 1'b1;

`ifdef RR_ARB_LOCK_EN
    // Burst lock: requester 0 sends 3 beats, requester 1 waits throughout
    set_data(1, 8'hD1);
    in_last  = '0;
    in_valid = 4'b0011;
    push(0, 8'hB0);
    push(0, 8'hB1);
    push(0, 8'hB2);
    push(1, 8'hD1);
    tick(1);
    for (int b = 0; b < 3; b++) begin
      set_data(0, 8'(8'hB0 + b));
      in_last[0] = (b == 2);
      #1;
      check("lk_ready0", 32'(in_ready), 32'b0001);
      tick(1);
    end
    in_valid = 4'b0010;
    in_last  = '1;
    tick(1);
    check("lk_ready1", 32'(in_ready), 32'b0010);
    tick(1);
    check("lk_sel1", 32'(out_sel), 32'd1);
    in_valid = '0;
    tick(2);
`else
    // Pointer returns to 0 after reset
    for (int i = 0; i < NR_REQ; i++) set_data(i, 8'(8'h20 + i));
    in_valid = '1;
    push(0, 8'h20);
    tick(1);
    check("ar_ptr_ready", 32'(in_ready), 32'b0001);
    tick(1);
    check("ar_ptr_sel", 32'(out_sel), 32'd0);
    in_valid = '0;
    tick(2);
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
